// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state type and counter-width helper for serial_adder.
package serial_adder_pkg;
  typedef enum logic {IDLE, SHIFT} adder_state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit combinational full adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic co,
  output logic sum
);
  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one shared full_adder; SERIAL_ADDER_OVF_EN adds ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CNT_W = cnt_w(WIDTH);
  adder_state_t state, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [CNT_W-1:0] cnt;
  logic carry, sum, co, last;
  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .co (co),
    .sum(sum)
  );
  assign last = (cnt == CNT_W'(WIDTH - 1));
  assign busy = (state == SHIFT);
  always_comb begin
    state_d = state;
    state_d = (state == IDLE) ? (start ? SHIFT : IDLE) : (last ? IDLE : SHIFT);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
      sum_out <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        a_sh   <= a_in;
        b_sh   <= b_in;
        carry  <= cin;
        cnt    <= '0;
        sum_sh <= '0;
      end else if (state == SHIFT) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        sum_sh <= {sum, sum_sh[WIDTH-1:1]};
        carry  <= co;
        cnt    <= cnt + 1'b1;
        if (last) begin
          sum_out <= {sum, sum_sh[WIDTH-1:1]};
          cout    <= co;
          done    <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
          // carry still holds the carry into the MSB on this edge
          ovf     <= carry ^ co;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder (WIDTH=8); checks ovf when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;
  localparam int W = 8;
  logic clk = 0, rst = 1, start = 0, cin = 0;
  logic [W-1:0] a_in = '0, b_in = '0, sum_out;
  logic busy, done, cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf;
`endif
  typedef struct {logic [W-1:0] s; logic c; logic v;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  logic prev_done = 0;
  logic [W-1:0] held = '0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy), .done(done), .sum_out(sum_out), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t e;
    logic [W:0] r;
    logic [W-1:0] lo;
    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    lo = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + {{(W-1){1'b0}}, c};
    e.s = r[W-1:0];
    e.c = r[W];
    e.v = lo[W-1] ^ r[W];
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (prev_done) check("done_pulse", done, 0);
    if (rst) held = '0;
    else if (done) begin
      check("sb_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("sum", sum_out, e.s);
        check("cout", cout, e.c);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", ovf, e.v);
`endif
      end
      held = sum_out;
    end else check("hold", sum_out, held);
    prev_done = done;
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit exp);
    @(negedge clk);
    a_in = a; b_in = b; cin = c; start = 1;
    if (exp) q.push_back(model(a, b, c));
    @(posedge clk); #1;
    start = 0; a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n;
    drive(a, b, c, 1);
    n = 0;
    while (!done && n < 20) begin
      check("busy", busy, 1);
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, W);
    check("busy_off", busy, 0);
  endtask

  initial begin
    int n;
    exp_t e;
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum_out, 0);
    check("rst_cout", cout, 0);
    #9 rst = 0;
    op(8'h5A, 8'h3C, 0);
    op(8'hFF, 8'h01, 0);
    op(8'hFF, 8'hFF, 1);
    // start issued on the 3rd busy cycle must be ignored
    drive(8'h10, 8'h20, 0, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_in = 8'h01; b_in = 8'h01; start = 1;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_start_lat", n, 5);
    repeat (12) begin
      @(posedge clk); #1;
      check("no_restart", busy, 0);
    end
    // back-to-back with start held high
    @(negedge clk);
    a_in = 8'h80; b_in = 8'h80; cin = 0; start = 1;
    q.push_back(model(8'h80, 8'h80, 0));
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      repeat (7) @(posedge clk);
      #1 check("b2b_early", done, 0);
      @(posedge clk); #1;
      check("b2b_done", done, 1);
      if (k < 3) begin
        a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
        q.push_back(model(a_in, b_in, cin));
        @(posedge clk); #1;
      end else start = 0;
    end
    op(8'h12, 8'h34, 0);
    // asynchronous reset on the 4th busy cycle
    drive(8'h33, 8'h44, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_sum", sum_out, 0);
    check("mid_rst_cout", cout, 0);
    @(negedge clk); #2 rst = 0;
    op(8'h07, 8'h09, 0);
    for (int i = 0; i < 1000; i++) op(W'($urandom), W'($urandom), 1'($urandom));
    repeat (3) @(posedge clk);
    check("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
